// File: rtl/pc_controller_pkg.sv
// Shared definitions for the PC controller front end: opcodes, truth/prediction
// constants, widths, BHT counter reset value and RISC-V immediate extraction.
package pc_controller_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    localparam logic TRUE      = 1'b1;
    localparam logic FALSE     = 1'b0;
    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    // Weakly not-taken.
    localparam logic [1:0] BHT_COUNTER_RESET = 2'b01;

    typedef enum logic {
        ISSUE,
        WAIT_INST
    } pc_state_e;

    function automatic logic [ADDRESS_WIDTH-1:0] j_imm(input logic [INSTRUCTION_WIDTH-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] b_imm(input logic [INSTRUCTION_WIDTH-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/pc_controller_bht.sv
// branch_history_table: array of 2-bit saturating counters with a combinational
// read port and a registered update port. Instantiated only under BHT_PREDICT_EN.
module branch_history_table
    import pc_controller_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_rdy,
    input  logic [INDEX_W-1:0] in_read_index,
    output logic [1:0]         out_read_counter,
    input  logic               in_update_enable,
    input  logic [INDEX_W-1:0] in_update_index,
    input  logic               in_update_taken
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic [1:0] counters [ENTRIES];
    logic [1:0] upd_counter;

    // A same-cycle update is not forwarded: the lookup sees the stored value.
    assign out_read_counter = counters[in_read_index];
    assign upd_counter      = counters[in_update_index];

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            // NOTE: the array is reset explicitly because every counter must start
            // weakly not-taken; this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= BHT_COUNTER_RESET;
            end
        end else if (in_rdy && in_update_enable) begin
            if (in_update_taken == TAKEN) begin
                if (upd_counter != 2'b11) begin
                    counters[in_update_index] <= upd_counter + 2'd1;
                end
            end else if (upd_counter != 2'b00) begin
                counters[in_update_index] <= upd_counter - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pc_controller.sv
// pc_controller: issues one fetch address at a time, predecodes the returned word
// and issues the next PC with the previous instruction's prediction. BHT_PREDICT_EN
// selects BHT-based branch prediction; otherwise static backward-taken.
module pc_controller
    import pc_controller_pkg::*;
#(
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = 32'h0,
    parameter int                       BHT_INDEX_W = 8
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         in_rdy,
    input  logic                         in_flush_enable,
    input  logic [ADDRESS_WIDTH-1:0]     in_flush_pc,
    input  logic                         in_fetch_full,
    input  logic                         in_last_enable,
    input  logic [INSTRUCTION_WIDTH-1:0] in_last_inst,
    input  logic                         in_bht_update_enable,
    input  logic [ADDRESS_WIDTH-1:0]     in_bht_update_pc,
    input  logic                         in_bht_update_taken,
    output logic                         out_fetcher_enable,
    output logic [ADDRESS_WIDTH-1:0]     out_pc,
    output logic                         out_predict
);

    pc_state_e                state;
    logic [ADDRESS_WIDTH-1:0] next_pc;
    logic [ADDRESS_WIDTH-1:0] cur_pc;
    logic                     next_pred;
    logic [ADDRESS_WIDTH-1:0] pd_pc;
    logic                     pd_pred;
    logic                     branch_taken;
    logic                     unused_inputs;

`ifdef BHT_PREDICT_EN
    logic [1:0] bht_counter;

    branch_history_table #(
        .INDEX_W(BHT_INDEX_W)
    ) u_bht (
        .in_clk           (in_clk),
        .in_rst           (in_rst),
        .in_rdy           (in_rdy),
        .in_read_index    (cur_pc[BHT_INDEX_W+1:2]),
        .out_read_counter (bht_counter),
        .in_update_enable (in_bht_update_enable),
        .in_update_index  (in_bht_update_pc[BHT_INDEX_W+1:2]),
        .in_update_taken  (in_bht_update_taken)
    );

    assign branch_taken  = bht_counter[1];
    assign unused_inputs = ^{bht_counter[0], in_bht_update_pc[ADDRESS_WIDTH-1:BHT_INDEX_W+2],
                             in_bht_update_pc[1:0]};
`else
    // Backward-taken / forward-not-taken: the B-immediate sign is inst[31].
    assign branch_taken  = in_last_inst[31];
    assign unused_inputs = ^{in_bht_update_enable, in_bht_update_pc, in_bht_update_taken};
`endif

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        pd_pc   = cur_pc + 32'd4;
        pd_pred = NOT_TAKEN;
        case (in_last_inst[6:0])
            OPCODE_JAL: begin
                pd_pc   = cur_pc + j_imm(in_last_inst);
                pd_pred = TAKEN;
            end
            OPCODE_BRANCH: begin
                if (branch_taken == TAKEN) begin
                    pd_pc   = cur_pc + b_imm(in_last_inst);
                    pd_pred = TAKEN;
                end
            end
            // The JALR target is register-relative and is corrected later by a flush.
            OPCODE_JALR: pd_pred = NOT_TAKEN;
            default:     pd_pred = NOT_TAKEN;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state              <= ISSUE;
            next_pc            <= RESET_PC;
            next_pred          <= NOT_TAKEN;
            cur_pc             <= '0;
            out_fetcher_enable <= FALSE;
            out_pc             <= '0;
            out_predict        <= NOT_TAKEN;
        end else if (in_rdy) begin
            out_fetcher_enable <= FALSE;
            if (in_flush_enable) begin
                // Any instruction word returning in the same cycle is stale.
                next_pc   <= in_flush_pc;
                next_pred <= NOT_TAKEN;
                state     <= ISSUE;
            end else begin
                case (state)
                    ISSUE: begin
                        if (!in_fetch_full) begin
                            out_fetcher_enable <= TRUE;
                            out_pc             <= next_pc;
                            out_predict        <= next_pred;
                            cur_pc             <= next_pc;
                            state              <= WAIT_INST;
                        end
                    end
                    WAIT_INST: begin
                        if (in_last_enable) begin
                            next_pc   <= pd_pc;
                            next_pred <= pd_pred;
                            state     <= ISSUE;
                        end
                    end
                    default: state <= ISSUE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: directed scenarios plus a randomized run
// against a behavioural model of issue order, predecode targets and BHT counters.
module tb_pc_controller;

    localparam int BHT_W   = 8;
    localparam int KIND_OTHER  = 0;
    localparam int KIND_JAL    = 1;
    localparam int KIND_BRANCH = 2;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic        in_rdy = 1'b1;
    logic        in_flush_enable = 1'b0;
    logic [31:0] in_flush_pc = '0;
    logic        in_fetch_full = 1'b0;
    logic        in_last_enable = 1'b0;
    logic [31:0] in_last_inst = '0;
    logic        in_bht_update_enable = 1'b0;
    logic [31:0] in_bht_update_pc = '0;
    logic        in_bht_update_taken = 1'b0;
    logic        out_fetcher_enable;
    logic [31:0] out_pc;
    logic        out_predict;

    pc_controller #(
        .RESET_PC    (32'h0),
        .BHT_INDEX_W (BHT_W)
    ) dut (
        .in_clk               (in_clk),
        .in_rst               (in_rst),
        .in_rdy               (in_rdy),
        .in_flush_enable      (in_flush_enable),
        .in_flush_pc          (in_flush_pc),
        .in_fetch_full        (in_fetch_full),
        .in_last_enable       (in_last_enable),
        .in_last_inst         (in_last_inst),
        .in_bht_update_enable (in_bht_update_enable),
        .in_bht_update_pc     (in_bht_update_pc),
        .in_bht_update_taken  (in_bht_update_taken),
        .out_fetcher_enable   (out_fetcher_enable),
        .out_pc               (out_pc),
        .out_predict          (out_predict)
    );

    always #5 in_clk = ~in_clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: the address/prediction waiting to be issued, the last
    // issued address, and one saturating counter per BHT entry.
    logic [31:0] m_next_pc;
    logic        m_next_pred;
    logic [31:0] m_cur_pc;
    int          m_bht [1 << BHT_W];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge in_clk);
    endtask

    function automatic int bht_index(input logic [31:0] pc);
        return int'((pc >> 2) % (1 << BHT_W));
    endfunction

    function automatic logic model_branch_taken(input logic [31:0] pc, input int imm);
`ifdef BHT_PREDICT_EN
        return m_bht[bht_index(pc)] >= 2;
`else
        return imm < 0;
`endif
    endfunction

    task automatic model_bht_update(input logic [31:0] pc, input logic taken);
        int idx = bht_index(pc);
        if (taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else       m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    endtask

    task automatic model_reset();
        m_next_pc   = 32'h0;
        m_next_pred = 1'b0;
        m_cur_pc    = 32'h0;
        for (int i = 0; i < (1 << BHT_W); i++) m_bht[i] = 1;
    endtask

    // Encodes an instruction of the given kind carrying imm; other fields random.
    function automatic logic [31:0] make_word(input int kind, input int imm, input logic [31:0] fill);
        logic [31:0] u;
        logic [6:0]  other_ops [4];
        u = imm;
        other_ops[0] = 7'b0010011;  // ADDI
        other_ops[1] = 7'b0110111;  // LUI
        other_ops[2] = 7'b1100111;  // JALR
        other_ops[3] = 7'b0000011;  // LOAD
        if (kind == KIND_JAL)
            return {u[20], u[10:1], u[11], u[19:12], fill[11:7], 7'b1101111};
        if (kind == KIND_BRANCH)
            return {u[12], u[10:5], fill[24:20], fill[19:15], fill[14:12], u[4:1], u[11], 7'b1100011};
        return {fill[31:7], other_ops[fill[1:0]]};
    endfunction

    // Next negedge must show the pulse carrying the model's pending address,
    // then one idle cycle with outputs held.
    task automatic expect_pulse(input string tag);
        tick();
        check({tag, ".en"},   {31'b0, out_fetcher_enable}, 32'd1);
        check({tag, ".pc"},   out_pc, m_next_pc);
        check({tag, ".pred"}, {31'b0, out_predict}, {31'b0, m_next_pred});
        m_cur_pc = m_next_pc;
        tick();
        check({tag, ".one_cycle"}, {31'b0, out_fetcher_enable}, 32'd0);
        check({tag, ".hold_pc"},   out_pc, m_cur_pc);
    endtask

    // Returns an instruction word for the last issued PC, optionally with the
    // queue full for nfull cycles and a same-cycle BHT update.
    task automatic feed(input string tag, input int kind, input int imm, input int nfull,
                        input logic upd_en, input logic [31:0] upd_pc, input logic upd_taken);
        logic t;
        in_last_inst         = make_word(kind, imm, $urandom);
        in_last_enable       = 1'b1;
        in_fetch_full        = (nfull > 0);
        in_bht_update_enable = upd_en;
        in_bht_update_pc     = upd_pc;
        in_bht_update_taken  = upd_taken;
        case (kind)
            KIND_JAL: begin
                m_next_pc   = m_cur_pc + 32'(imm);
                m_next_pred = 1'b1;
            end
            KIND_BRANCH: begin
                t           = model_branch_taken(m_cur_pc, imm);
                m_next_pc   = t ? m_cur_pc + 32'(imm) : m_cur_pc + 32'd4;
                m_next_pred = t;
            end
            default: begin
                m_next_pc   = m_cur_pc + 32'd4;
                m_next_pred = 1'b0;
            end
        endcase
        if (upd_en) model_bht_update(upd_pc, upd_taken);
        tick();
        in_last_enable       = 1'b0;
        in_bht_update_enable = 1'b0;
        for (int i = 0; i < nfull; i++) begin
            check({tag, ".full_hold"}, {31'b0, out_fetcher_enable}, 32'd0);
            tick();
        end
        in_fetch_full = 1'b0;
        check({tag, ".latency"}, {31'b0, out_fetcher_enable}, 32'd0);
        expect_pulse(tag);
    endtask

    task automatic do_flush(input string tag, input logic [31:0] pc, input logic with_inst);
        in_flush_enable = 1'b1;
        in_flush_pc     = pc;
        in_last_enable  = with_inst;
        in_last_inst    = make_word(KIND_JAL, 64, $urandom);
        tick();
        in_flush_enable = 1'b0;
        in_last_enable  = 1'b0;
        m_next_pc       = pc;
        m_next_pred     = 1'b0;
        check({tag, ".latency"}, {31'b0, out_fetcher_enable}, 32'd0);
        expect_pulse(tag);
    endtask

    task automatic bht_train(input logic [31:0] pc, input logic taken, input int times);
        for (int i = 0; i < times; i++) begin
            in_bht_update_enable = 1'b1;
            in_bht_update_pc     = pc;
            in_bht_update_taken  = taken;
            model_bht_update(pc, taken);
            tick();
        end
        in_bht_update_enable = 1'b0;
    endtask

    initial begin
        int kind;
        int imm;
        int nfull;
        logic [31:0] upc;

        // Reset state and sequential fetch.
        model_reset();
        in_rst = 1'b1;
        tick();
        tick();
        check("reset.en",   {31'b0, out_fetcher_enable}, 32'd0);
        check("reset.pc",   out_pc, 32'h0);
        check("reset.pred", {31'b0, out_predict}, 32'd0);
        in_rst = 1'b0;
        expect_pulse("first_issue");
        feed("seq4", KIND_OTHER, 0, 0, 1'b0, '0, 1'b0);
        check("seq4.addr", out_pc, 32'h4);
        feed("seq8", KIND_OTHER, 0, 0, 1'b0, '0, 1'b0);
        check("seq8.addr", out_pc, 32'h8);

        // JAL forward.
        do_flush("flush10", 32'h10, 1'b0);
        feed("jal", KIND_JAL, 32'h20, 0, 1'b0, '0, 1'b0);
        check("jal.addr", out_pc, 32'h30);

        // Stalled global ready: nothing sampled, BHT untouched.
        do_flush("flush40a", 32'h40, 1'b0);
        in_rdy               = 1'b0;
        in_last_enable       = 1'b1;
        in_last_inst         = make_word(KIND_JAL, 256, $urandom);
        in_bht_update_enable = 1'b1;
        in_bht_update_pc     = 32'h40;
        in_bht_update_taken  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_low.en", {31'b0, out_fetcher_enable}, 32'd0);
            check("rdy_low.pc", out_pc, 32'h40);
        end
        in_last_enable       = 1'b0;
        in_bht_update_enable = 1'b0;
        in_rdy               = 1'b1;

        // BEQ backward at 0x40 before and after training.
        feed("beq_cold", KIND_BRANCH, -8, 0, 1'b0, '0, 1'b0);
`ifdef BHT_PREDICT_EN
        check("beq_cold.addr", out_pc, 32'h44);
`else
        check("beq_cold.addr", out_pc, 32'h38);
`endif
        bht_train(32'h40, 1'b1, 2);
        do_flush("flush40b", 32'h40, 1'b0);
        feed("beq_warm", KIND_BRANCH, -8, 0, 1'b0, '0, 1'b0);
        check("beq_warm.addr", out_pc, 32'h38);
        check("beq_warm.pred", {31'b0, out_predict}, 32'd1);

        // Fetch queue full for five cycles.
        feed("full5", KIND_OTHER, 0, 5, 1'b0, '0, 1'b0);

        // Flush beats a coincident instruction return.
        do_flush("flush_vs_inst", 32'h100, 1'b1);
        check("flush_vs_inst.addr", out_pc, 32'h100);

        // Counter saturation at both ends.
        bht_train(32'h100, 1'b0, 4);
        feed("sat_low", KIND_BRANCH, -16, 0, 1'b0, '0, 1'b0);
        bht_train(32'h104, 1'b0, 4);
        bht_train(32'hF0, 1'b1, 4);
        do_flush("flushF0", 32'hF0, 1'b0);
        bht_train(32'hF0, 1'b0, 1);
        feed("sat_high", KIND_BRANCH, 64, 0, 1'b0, '0, 1'b0);
`ifdef BHT_PREDICT_EN
        check("sat_high.pred", {31'b0, out_predict}, 32'd1);
`endif

        // Lookup and update of the same index in one cycle sees the old counter.
        do_flush("flush200", 32'h200, 1'b0);
        bht_train(32'h200, 1'b1, 1);
        feed("same_cycle", KIND_BRANCH, 32, 0, 1'b1, 32'h200, 1'b0);

        // Address wrap.
        do_flush("flush_top", 32'hFFFF_FFFC, 1'b0);
        feed("wrap", KIND_OTHER, 0, 0, 1'b0, '0, 1'b0);
        check("wrap.addr", out_pc, 32'h0);
        feed("jal_neg_wrap", KIND_JAL, -8, 0, 1'b0, '0, 1'b0);

        // Reset while waiting for an instruction.
        in_rst         = 1'b1;
        in_last_enable = 1'b1;
        in_last_inst   = make_word(KIND_JAL, 128, $urandom);
        tick();
        in_rst         = 1'b0;
        in_last_enable = 1'b0;
        model_reset();
        check("mid_reset.en", {31'b0, out_fetcher_enable}, 32'd0);
        expect_pulse("mid_reset");

        // Randomized run.
        for (int n = 0; n < 60; n++) begin
            kind  = int'($urandom_range(0, 2));
            imm   = (kind == KIND_JAL) ? int'($urandom_range(0, 1048575)) * 2 - 1048576
                                       : int'($urandom_range(0, 4095)) * 2 - 4096;
            nfull = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            upc   = ($urandom_range(0, 1) == 0) ? m_cur_pc : {22'b0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0)
                do_flush("rnd_flush", {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                bht_train(upc, $urandom_range(0, 1) == 1, int'($urandom_range(1, 3)));
            feed("rnd", kind, imm, nfull, $urandom_range(0, 1) == 1, upc, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
